// File: rtl/interrupt_controller_pkg.sv
// Shared CPU definitions for the interrupt path: controller FSM encoding,
// default vector base and the pipeline's ack/done handshake.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQUEST = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_t;

    localparam logic [15:0] IC_VECTOR_BASE = 16'h0002;

    // Pipeline-to-controller handshake. Fetch raises ack when it pushes the
    // PC; decode raises done when the return-from-interrupt retires.
    typedef struct packed {
        logic ack;
        logic done;
    } int_hs_t;

endpackage

// File: rtl/interrupt_controller_edge_sync.sv
// Two-flop synchroniser plus history flop per interrupt line; o_edge is a
// single-cycle pulse on each synchronised rising edge.
module irq_edge_sync #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_line,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] h;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s1 <= '0;
            s2 <= '0;
            h  <= '0;
        end else begin
            s1 <= i_line;
            s2 <= s1;
            h  <= s2;
        end
    end

    // History clears on reset, so a line already high yields one edge.
    assign o_edge = s2 & ~h;

endmodule

// File: rtl/interrupt_controller.sv
// Non-nested interrupt initiator: latches synchronised rising edges, picks the
// lowest-index unmasked pending source and tracks it through ack and done.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SOURCES = 4,
    parameter logic [15:0] VECTOR_BASE = IC_VECTOR_BASE,
    parameter int          ID_WIDTH    = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_SOURCES-1:0] i_irq,
    input  logic [NUM_SOURCES-1:0] i_mask,
    input  logic                   i_int_ack,
    input  logic                   i_int_done,
    output logic                   o_interrupt,
    output logic [15:0]            o_vector,
    output logic [ID_WIDTH-1:0]    o_int_id,
    output logic [NUM_SOURCES-1:0] o_pending,
    output logic                   o_in_service
);

    ic_state_t              state_q, state_d;
    logic [NUM_SOURCES-1:0] pend_q, pend_d;
    logic [NUM_SOURCES-1:0] clr;
    logic [NUM_SOURCES-1:0] irq_edge;
    logic [NUM_SOURCES-1:0] eligible;
    logic                   win_vld;
    logic [ID_WIDTH-1:0]    win_id;
    logic                   int_q, int_d;
    logic                   svc_q, svc_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [15:0]            vec_q, vec_d;
    int_hs_t                hs;

    assign hs.ack  = i_int_ack;
    assign hs.done = i_int_done;

    irq_edge_sync #(.WIDTH(NUM_SOURCES)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_line  (i_irq),
        .o_edge  (irq_edge)
    );

    assign eligible = pend_q & ~i_mask;

    // Scan downward so the lowest eligible index is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int n = NUM_SOURCES - 1; n >= 0; n--) begin
            if (eligible[n]) begin
                win_vld = 1'b1;
                win_id  = ID_WIDTH'(n);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        svc_d   = svc_q;
        id_d    = id_q;
        vec_d   = vec_q;
        clr     = '0;
        case (state_q)
            IC_IDLE: begin
                if (win_vld) begin
                    id_d    = win_id;
                    vec_d   = VECTOR_BASE + 16'(win_id);
                    int_d   = 1'b1;
                    state_d = IC_REQUEST;
                end
            end
            IC_REQUEST: begin
                if (hs.ack) begin
                    for (int n = 0; n < NUM_SOURCES; n++) begin
                        if (ID_WIDTH'(n) == id_q) clr[n] = 1'b1;
                    end
                    int_d   = 1'b0;
                    svc_d   = 1'b1;
                    state_d = IC_SERVICE;
                end
            end
            IC_SERVICE: begin
                if (hs.done) begin
                    svc_d   = 1'b0;
                    state_d = IC_IDLE;
                end
            end
            default: begin
                int_d   = 1'b0;
                svc_d   = 1'b0;
                state_d = IC_IDLE;
            end
        endcase
        // A fresh edge landing with the ack is kept as a new request.
        pend_d = (pend_q & ~clr) | irq_edge;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IC_IDLE;
            pend_q  <= '0;
            int_q   <= 1'b0;
            svc_q   <= 1'b0;
            id_q    <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            int_q   <= int_d;
            svc_q   <= svc_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
        end
    end

    assign o_interrupt  = int_q;
    assign o_in_service = svc_q;
    assign o_int_id     = id_q;
    assign o_vector     = vec_q;
    assign o_pending    = pend_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: per-cycle vector table for the
// handshake/priority/mask/set-wins cases, hand sequences around reset.
module tb_interrupt_controller;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_irq;
    logic [3:0]  i_mask;
    logic        i_int_ack;
    logic        i_int_done;
    logic        o_interrupt;
    logic [15:0] o_vector;
    logic [2:0]  o_int_id;
    logic [3:0]  o_pending;
    logic        o_in_service;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        ack;
        logic        done;
        logic        e_int;
        logic [2:0]  e_id;
        logic [15:0] e_vec;
        logic [3:0]  e_pend;
        logic        e_svc;
    } vec_t;

    vec_t tbl[$];

    interrupt_controller #(
        .NUM_SOURCES (4),
        .VECTOR_BASE (16'h0002),
        .ID_WIDTH    (3)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_irq        (i_irq),
        .i_mask       (i_mask),
        .i_int_ack    (i_int_ack),
        .i_int_done   (i_int_done),
        .o_interrupt  (o_interrupt),
        .o_vector     (o_vector),
        .o_int_id     (o_int_id),
        .o_pending    (o_pending),
        .o_in_service (o_in_service)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_int, input logic [2:0] e_id,
                           input logic [15:0] e_vec, input logic [3:0] e_pend, input logic e_svc);
        chk({tag, " interrupt"},  16'(o_interrupt),  16'(e_int));
        chk({tag, " int_id"},     16'(o_int_id),     16'(e_id));
        chk({tag, " vector"},     o_vector,          e_vec);
        chk({tag, " pending"},    16'(o_pending),    16'(e_pend));
        chk({tag, " in_service"}, 16'(o_in_service), 16'(e_svc));
    endtask

    task automatic add(input logic [3:0] irq, input logic [3:0] mask, input logic ack,
                       input logic done, input logic e_int, input logic [2:0] e_id,
                       input logic [15:0] e_vec, input logic [3:0] e_pend, input logic e_svc);
        vec_t v;
        v = '{irq, mask, ack, done, e_int, e_id, e_vec, e_pend, e_svc};
        tbl.push_back(v);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Handshake / latency
        add(4'b0100, 4'b0000, 0, 0, 0, 3'd0, 16'h0000, 4'b0000, 0);
        add(4'b0100, 4'b0000, 0, 0, 0, 3'd0, 16'h0000, 4'b0000, 0);
        add(4'b0100, 4'b0000, 0, 0, 0, 3'd0, 16'h0000, 4'b0100, 0);
        add(4'b0100, 4'b0000, 0, 0, 1, 3'd2, 16'h0004, 4'b0100, 0);
        add(4'b0000, 4'b0000, 1, 0, 0, 3'd2, 16'h0004, 4'b0000, 1);
        add(4'b0000, 4'b0000, 1, 0, 0, 3'd2, 16'h0004, 4'b0000, 1); // stray ack
        add(4'b0000, 4'b0000, 0, 1, 0, 3'd2, 16'h0004, 4'b0000, 0);
        // Priority, no preemption
        add(4'b1010, 4'b0000, 0, 0, 0, 3'd2, 16'h0004, 4'b0000, 0);
        add(4'b1010, 4'b0000, 0, 0, 0, 3'd2, 16'h0004, 4'b0000, 0);
        add(4'b1010, 4'b0000, 0, 0, 0, 3'd2, 16'h0004, 4'b1010, 0);
        add(4'b1010, 4'b0000, 0, 0, 1, 3'd1, 16'h0003, 4'b1010, 0);
        add(4'b1011, 4'b0000, 0, 1, 1, 3'd1, 16'h0003, 4'b1010, 0); // done ignored
        add(4'b1011, 4'b0000, 0, 0, 1, 3'd1, 16'h0003, 4'b1010, 0);
        add(4'b1011, 4'b0000, 0, 0, 1, 3'd1, 16'h0003, 4'b1011, 0);
        add(4'b1011, 4'b0000, 1, 0, 0, 3'd1, 16'h0003, 4'b1001, 1);
        add(4'b0000, 4'b0000, 0, 1, 0, 3'd1, 16'h0003, 4'b1001, 0);
        add(4'b0000, 4'b0000, 0, 0, 1, 3'd0, 16'h0002, 4'b1001, 0);
        add(4'b0000, 4'b0000, 1, 0, 0, 3'd0, 16'h0002, 4'b1000, 1);
        add(4'b0000, 4'b0000, 0, 1, 0, 3'd0, 16'h0002, 4'b1000, 0);
        add(4'b0000, 4'b0000, 0, 0, 1, 3'd3, 16'h0005, 4'b1000, 0);
        add(4'b0000, 4'b0000, 1, 0, 0, 3'd3, 16'h0005, 4'b0000, 1);
        add(4'b0000, 4'b0000, 0, 1, 0, 3'd3, 16'h0005, 4'b0000, 0);
        // Masking
        add(4'b0010, 4'b0010, 0, 0, 0, 3'd3, 16'h0005, 4'b0000, 0);
        add(4'b0010, 4'b0010, 0, 0, 0, 3'd3, 16'h0005, 4'b0000, 0);
        add(4'b0010, 4'b0010, 0, 0, 0, 3'd3, 16'h0005, 4'b0010, 0);
        add(4'b0010, 4'b0010, 0, 0, 0, 3'd3, 16'h0005, 4'b0010, 0);
        add(4'b0000, 4'b0000, 0, 0, 1, 3'd1, 16'h0003, 4'b0010, 0);
        add(4'b0000, 4'b0000, 1, 0, 0, 3'd1, 16'h0003, 4'b0000, 1);
        add(4'b0000, 4'b0000, 0, 1, 0, 3'd1, 16'h0003, 4'b0000, 0);
        // Set wins over clear
        add(4'b0100, 4'b0000, 0, 0, 0, 3'd1, 16'h0003, 4'b0000, 0);
        add(4'b0100, 4'b0000, 0, 0, 0, 3'd1, 16'h0003, 4'b0000, 0);
        add(4'b0100, 4'b0000, 0, 0, 0, 3'd1, 16'h0003, 4'b0100, 0);
        add(4'b0100, 4'b0000, 0, 0, 1, 3'd2, 16'h0004, 4'b0100, 0);
        add(4'b0000, 4'b0000, 0, 0, 1, 3'd2, 16'h0004, 4'b0100, 0);
        add(4'b0100, 4'b0000, 0, 0, 1, 3'd2, 16'h0004, 4'b0100, 0);
        add(4'b0100, 4'b0000, 0, 0, 1, 3'd2, 16'h0004, 4'b0100, 0);
        add(4'b0100, 4'b0000, 1, 0, 0, 3'd2, 16'h0004, 4'b0100, 1);
        add(4'b0100, 4'b0000, 0, 1, 0, 3'd2, 16'h0004, 4'b0100, 0);
        add(4'b0100, 4'b0000, 0, 0, 1, 3'd2, 16'h0004, 4'b0100, 0);
        add(4'b0000, 4'b0000, 1, 0, 0, 3'd2, 16'h0004, 4'b0000, 1);
        add(4'b0000, 4'b0000, 0, 1, 0, 3'd2, 16'h0004, 4'b0000, 0);

        // Reset values with all lines high, then one edge per line
        i_reset = 1'b0; i_irq = 4'b1111; i_mask = 4'b0000;
        i_int_ack = 1'b0; i_int_done = 1'b0;
        repeat (2) tick();
        chk_all("reset", 0, 3'd0, 16'h0000, 4'b0000, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        tick(); chk_all("rel_e1", 0, 3'd0, 16'h0000, 4'b0000, 0);
        tick(); chk_all("rel_e2", 0, 3'd0, 16'h0000, 4'b0000, 0);
        tick(); chk_all("rel_e3", 0, 3'd0, 16'h0000, 4'b1111, 0);
        tick(); chk_all("rel_e4", 1, 3'd0, 16'h0002, 4'b1111, 0);

        i_irq = 4'b0000; i_reset = 1'b0;
        tick();
        @(negedge i_clk);
        i_reset = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            i_irq      = tbl[k].irq;
            i_mask     = tbl[k].mask;
            i_int_ack  = tbl[k].ack;
            i_int_done = tbl[k].done;
            tick();
            chk_all($sformatf("row%0d", k), tbl[k].e_int, tbl[k].e_id,
                    tbl[k].e_vec, tbl[k].e_pend, tbl[k].e_svc);
        end
        i_int_ack = 1'b0; i_int_done = 1'b0;

        // Reset in SERVICE with pending[3] outstanding
        i_irq = 4'b1001;
        tick(); tick();
        tick(); chk_all("r6_pend", 0, 3'd2, 16'h0004, 4'b1001, 0);
        tick(); chk_all("r6_req",  1, 3'd0, 16'h0002, 4'b1001, 0);
        i_int_ack = 1'b1;
        tick(); chk_all("r6_svc",  0, 3'd0, 16'h0002, 4'b1000, 1);
        i_int_ack = 1'b0;
        #2;
        i_reset = 1'b0; i_irq = 4'b0000;
        #1;
        chk_all("r6_async", 0, 3'd0, 16'h0000, 4'b0000, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (6) tick();
        chk_all("r6_after", 0, 3'd0, 16'h0000, 4'b0000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Initiator side of the CPU interrupt interface; drives the fetch stage's interrupt input, which is currently tied low in the integration.
- Synchronises external interrupt pins and latches rising edges as pending requests.
- Picks the highest-priority unmasked request, asserts it to the pipeline, and tracks it until the pipeline acknowledges entry (PC pushed) and later signals return (PC popped).
- Non-nested: one interrupt in service at a time.

Parameters:
- NUM_SOURCES, 4: number of external interrupt lines, range 1..8.
- VECTOR_BASE, 16'h0002: memory address of the vector-table entry for source 0.
- ID_WIDTH, 3: width of the source index; must satisfy 2**ID_WIDTH >= NUM_SOURCES.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_irq  in  NUM_SOURCES  asynchronous interrupt pins, rising-edge sensitive.
- i_mask  in  NUM_SOURCES  1 = source blocked from being selected; its pending bit is still latched.
- i_int_ack  in  1  one-cycle pulse from the pipeline: interrupt accepted, PC pushed.
- i_int_done  in  1  one-cycle pulse from the pipeline: return-from-interrupt retired, PC popped.
- o_interrupt  out  1  request to the fetch stage; held high until acknowledged.
- o_vector  out  16  vector-table address of the current request.
- o_int_id  out  ID_WIDTH  index of the current or in-service source.
- o_pending  out  NUM_SOURCES  pending request bits.
- o_in_service  out  1  high from acknowledge until done.

Behaviour:
- **Reset** (i_reset=0, asynchronous): state=IDLE; all synchroniser, edge-history and pending flops cleared; o_interrupt=0, o_vector=0, o_int_id=0, o_pending=0, o_in_service=0. Reset mid-request or mid-service abandons it with no residual pending.
- **Synchroniser:** per line, a 2-flop sync (s1, s2) plus history flop h. edge[n] = s2[n] & ~h[n].
  - A line held high across reset release therefore yields exactly one edge.
- **Pending bits:**
  - Set on edge[n].
  - Cleared when i_int_ack arrives in REQUEST for the selected id.
  - Same-cycle set and clear on the same n: set wins, so the new edge is kept.
  - Further edges while a bit is already pending are merged into it (no count).
- **Edge-to-request latency:**
  - Pin first sampled high at edge E0 → s2=1 after E1 → pending=1 after E2 → o_interrupt=1 after E3, if IDLE and unmasked.
  - Line must stay high ≥2 cycles to be guaranteed caught.
- **Priority:** lowest index wins among (o_pending & ~i_mask).
- **FSM, all outputs registered:**
  - IDLE:
    - If any eligible bit: latch id = winner, o_vector = VECTOR_BASE + id (16-bit zero-extended add, wraps modulo 2^16), o_interrupt=1; go to REQUEST.
    - i_int_ack and i_int_done are ignored.
  - REQUEST:
    - Hold o_interrupt, o_int_id and o_vector stable. Later mask changes or higher-priority arrivals do not preempt.
    - On i_int_ack: clear pending[id], o_interrupt=0, o_in_service=1; go to SERVICE.
    - i_int_done is ignored.
  - SERVICE:
    - New edges keep latching.
    - On i_int_done: o_in_service=0; go to IDLE.
    - A stray i_int_ack is ignored.
    - The next request can assert no earlier than the cycle after returning to IDLE, i.e. the second edge after the done pulse.
- **Simultaneous ack and done** in any state: only the one relevant to the current state acts.
- o_pending mirrors the pending register directly.

Decomposition:
- Shared CPU package gets:
  - FSM state encoding: IC_IDLE=2'd0, IC_REQUEST=2'd1, IC_SERVICE=2'd2.
  - Default VECTOR_BASE constant.
  - Interrupt ack/done signal naming, so the fetch and decode stages use the same definitions.
- One natural sub-module, irq_edge_sync: the per-line 2-flop synchroniser plus rising-edge detect, instantiated with NUM_SOURCES width.
- Priority select, pending register and FSM stay in the top block.

Test Plan:
1. **Reset values:** hold i_reset=0 with i_irq=4'b1111 → all outputs 0. Release reset → one edge per line: o_pending=4'b1111 after 3 edges; after the 4th edge o_interrupt=1, o_int_id=0, o_vector=16'h0002.
2. **Handshake and latency:** i_irq[2] rises, sampled at E0, mask=0 → o_pending=4'b0100 after E2; o_interrupt=1, o_int_id=2, o_vector=16'h0004 after E3. Pulse i_int_ack → next cycle o_interrupt=0, o_in_service=1, o_pending=0. Pulse i_int_done → o_in_service=0, IDLE.
3. **Priority and no preemption:** raise i_irq[3] and i_irq[1] together → id=1 served first. While in REQUEST, raise i_irq[0] → id stays 1. After ack and done, id=0 is served, then id=3.
4. **Masking:** i_mask=4'b0010 with i_irq[1] edge → o_pending=4'b0010, o_interrupt stays 0. Clear the mask → o_interrupt=1, id=1 on the next edge.
5. **Set wins over clear:** a new i_irq[2] edge lands on the same cycle as i_int_ack for id=2 → pending[2] stays 1, and it is served again after done.
6. **Reset mid-service:** assert reset while in SERVICE with pending=4'b1000 → all outputs 0 immediately (asynchronous). After release with i_irq low, no interrupt is raised.
